// File: rtl/shifter_if.sv
// shifter_if: operand/result valid-ready handshake bundle for iter_shifter.
interface shifter_if #(
    parameter int SIZE = 32
);
    localparam int SHW = $clog2(SIZE);
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] in_data;
    logic [SHW-1:0]  in_shamt;
    logic [1:0]      in_mode;
    logic            out_valid;
    logic            out_ready;
    logic [SIZE-1:0] out_data;
    logic            busy;
    modport master(
        output in_valid, in_data, in_shamt, in_mode, out_ready,
        input  in_ready, out_valid, out_data, busy
    );
    modport slave(
        input  in_valid, in_data, in_shamt, in_mode, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle SLL/SRL/SRA/ROTR shifter that moves at most STEP bit
// positions per clock, with valid/ready handshakes on operand and result.
module iter_shifter #(
    parameter int SIZE = 32,
    parameter int STEP = 8,
    parameter int SHW  = $clog2(SIZE)
) (
    input logic      clk,
    input logic      rst_n,
    shifter_if.slave s
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    // rem never exceeds SIZE-1, so clamping the step there keeps it in SHW bits
    localparam logic [SHW-1:0] KMAX = SHW'(STEP >= SIZE ? SIZE - 1 : STEP);
    state_t                 state_q, state_d;
    logic [SIZE-1:0]        acc_q, acc_d, stepped;
    logic signed [SIZE-1:0] sra;
    logic [SHW-1:0]         rem_q, rem_d, k;
    logic [1:0]             mode_q, mode_d;

    assign k   = rem_q < KMAX ? rem_q : KMAX;
    assign sra = $signed(acc_q) >>> k;
    // rotate-right by k: the wrapped part is a left shift by (SIZE-k) mod SIZE, i.e. -k
    assign stepped = mode_q == 2'd0 ? acc_q << k :
                     mode_q == 2'd1 ? acc_q >> k :
                     mode_q == 2'd2 ? $unsigned(sra) :
                     (acc_q >> k) | (acc_q << (SHW'(0) - k));

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: if (s.in_valid) begin
                acc_d   = s.in_data;
                rem_d   = s.in_shamt;
                mode_d  = s.in_mode;
                state_d = s.in_shamt == '0 ? DONE : SHIFT;
            end
            SHIFT: begin
                acc_d   = stepped;
                rem_d   = rem_q - k;
                state_d = rem_q == k ? DONE : SHIFT;
            end
            DONE:    state_d = s.out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            mode_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
        end
    end

    assign s.in_ready  = state_q == IDLE;
    assign s.out_valid = state_q == DONE;
    assign s.busy      = state_q != IDLE;
    assign s.out_data  = acc_q;
endmodule

// File: tb/tb_iter_shifter.sv
// tb_iter_shifter: randomized and directed checks of iter_shifter for STEP = 1, 8, 32
// against an arithmetic reference model.
module tb_iter_shifter;
    logic        clk = 0;
    logic        rst_n = 0;
    int          sel = 1;
    logic        in_valid = 0;
    logic [31:0] in_data = 0;
    logic [4:0]  in_shamt = 0;
    logic [1:0]  in_mode = 0;
    logic        out_ready = 0;
    logic        in_ready_m, out_valid_m, busy_m;
    logic [31:0] out_data_m;
    int          checks = 0;
    int          errors = 0;
    int          steps[3] = '{1, 8, 32};

    always #5 clk = ~clk;

    shifter_if #(.SIZE(32)) i0 ();
    shifter_if #(.SIZE(32)) i1 ();
    shifter_if #(.SIZE(32)) i2 ();

    iter_shifter #(.SIZE(32), .STEP(1))  u0 (.clk(clk), .rst_n(rst_n), .s(i0));
    iter_shifter #(.SIZE(32), .STEP(8))  u1 (.clk(clk), .rst_n(rst_n), .s(i1));
    iter_shifter #(.SIZE(32), .STEP(32)) u2 (.clk(clk), .rst_n(rst_n), .s(i2));

    assign i0.in_valid  = in_valid && sel == 0;
    assign i1.in_valid  = in_valid && sel == 1;
    assign i2.in_valid  = in_valid && sel == 2;
    assign i0.out_ready = out_ready && sel == 0;
    assign i1.out_ready = out_ready && sel == 1;
    assign i2.out_ready = out_ready && sel == 2;
    assign i0.in_data = in_data;  assign i0.in_shamt = in_shamt;  assign i0.in_mode = in_mode;
    assign i1.in_data = in_data;  assign i1.in_shamt = in_shamt;  assign i1.in_mode = in_mode;
    assign i2.in_data = in_data;  assign i2.in_shamt = in_shamt;  assign i2.in_mode = in_mode;

    assign in_ready_m  = sel == 0 ? i0.in_ready  : sel == 1 ? i1.in_ready  : i2.in_ready;
    assign out_valid_m = sel == 0 ? i0.out_valid : sel == 1 ? i1.out_valid : i2.out_valid;
    assign busy_m      = sel == 0 ? i0.busy      : sel == 1 ? i1.busy      : i2.busy;
    assign out_data_m  = sel == 0 ? i0.out_data  : sel == 1 ? i1.out_data  : i2.out_data;

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int sh, input logic [1:0] md);
        logic [63:0] w;
        case (md)
            2'd0:    w = {32'd0, d} << sh;
            2'd1:    w = {32'd0, d} >> sh;
            2'd2:    w = {{32{d[31]}}, d} >> sh;
            default: w = {d, d} >> sh;
        endcase
        return w[31:0];
    endfunction

    function automatic int exp_lat(input int sh, input int step);
        return (sh + step - 1) / step + 1;
    endfunction

    task automatic do_op(input logic [31:0] d, input logic [4:0] sh, input logic [1:0] md,
                         output logic [31:0] res, output int lat, output bit busy_ok, output bit rdy_ok);
        @(negedge clk);
        rdy_ok   = in_ready_m;
        in_valid = 1;
        in_data  = d;
        in_shamt = sh;
        in_mode  = md;
        @(posedge clk);
        #1;
        in_valid = 0;
        in_data  = $urandom;
        in_shamt = 5'($urandom);
        in_mode  = 2'($urandom);
        lat      = 1;
        busy_ok  = 1;
        while (!out_valid_m && lat < 100) begin
            busy_ok = busy_ok && busy_m;
            @(posedge clk);
            #1;
            lat++;
        end
        busy_ok = busy_ok && busy_m;
        res     = out_data_m;
    endtask

    task automatic drain(output bit ok);
        @(negedge clk);
        out_ready = 1;
        @(posedge clk);
        #1;
        out_ready = 0;
        ok = in_ready_m && !out_valid_m && !busy_m;
    endtask

    task automatic test_reset;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checks++;
            if (out_valid_m !== 1'b0 || busy_m !== 1'b0 || in_ready_m !== 1'b1 || out_data_m !== 32'd0) begin
                errors++;
                $display("FAIL reset step=%0d: valid=%b busy=%b ready=%b data=%h, want 0 0 1 00000000",
                         steps[s], out_valid_m, busy_m, in_ready_m, out_data_m);
            end
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_directed;
        logic [31:0] vd[5] = '{32'h0000_0001, 32'h8000_0000, 32'h8000_0000, 32'h0000_00F1, 32'h1234_5678};
        logic [4:0]  vs[5] = '{5'd2, 5'd31, 5'd31, 5'd4, 5'd0};
        logic [1:0]  vm[5] = '{2'd0, 2'd2, 2'd1, 2'd3, 2'd3};
        logic [31:0] ve[5] = '{32'h0000_0004, 32'hFFFF_FFFF, 32'h0000_0001, 32'h1000_000F, 32'h1234_5678};
        int          vl[5] = '{2, 5, 5, 2, 1};
        logic [31:0] res;
        int          lat;
        bit          bok, rok, dok;
        sel = 1;
        for (int i = 0; i < 5; i++) begin
            do_op(vd[i], vs[i], vm[i], res, lat, bok, rok);
            checks++;
            if (res !== ve[i] || lat != vl[i] || !bok || !rok) begin
                errors++;
                $display("FAIL directed[%0d]: data=%h lat=%0d busy_ok=%0b ready_ok=%0b, want data=%h lat=%0d 1 1",
                         i, res, lat, bok, rok, ve[i], vl[i]);
            end
            drain(dok);
            checks++;
            if (!dok) begin
                errors++;
                $display("FAIL directed_drain[%0d]: ready=%b valid=%b busy=%b, want 1 0 0", i, in_ready_m, out_valid_m, busy_m);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] res;
        int          lat;
        bit          bok, rok, dok;
        sel = 1;
        do_op(32'hA5A5_0F0F, 5'd12, 2'd3, res, lat, bok, rok);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = 1;
            in_data  = $urandom;
            in_shamt = 5'($urandom);
            in_mode  = 2'($urandom);
            @(posedge clk);
            #1;
            checks++;
            if (out_valid_m !== 1'b1 || in_ready_m !== 1'b0 || out_data_m !== ref_shift(32'hA5A5_0F0F, 12, 2'd3)) begin
                errors++;
                $display("FAIL backpressure[%0d]: valid=%b ready=%b data=%h, want 1 0 %h",
                         c, out_valid_m, in_ready_m, out_data_m, ref_shift(32'hA5A5_0F0F, 12, 2'd3));
            end
        end
        in_valid = 0;
        drain(dok);
        checks++;
        if (!dok) begin
            errors++;
            $display("FAIL backpressure_drain: ready=%b valid=%b busy=%b, want 1 0 0", in_ready_m, out_valid_m, busy_m);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid_m !== 1'b0 || busy_m !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_ignored: valid=%b busy=%b, want 0 0", out_valid_m, busy_m);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] res;
        int          lat;
        bit          bok, rok, dok;
        sel = 1;
        @(negedge clk);
        in_valid = 1;
        in_data  = 32'h0000_0ABC;
        in_shamt = 5'd20;
        in_mode  = 2'd0;
        @(posedge clk);
        #1;
        in_valid = 0;
        @(posedge clk);
        #1;
        checks++;
        if (busy_m !== 1'b1 || out_valid_m !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_shifting: busy=%b valid=%b, want 1 0", busy_m, out_valid_m);
        end
        rst_n = 0;
        #1;
        checks++;
        if (out_valid_m !== 1'b0 || busy_m !== 1'b0 || in_ready_m !== 1'b1 || out_data_m !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_clear: valid=%b busy=%b ready=%b data=%h, want 0 0 1 00000000",
                     out_valid_m, busy_m, in_ready_m, out_data_m);
        end
        repeat (2) @(negedge clk);
        rst_n = 1;
        do_op(32'hFF00_0000, 5'd8, 2'd1, res, lat, bok, rok);
        checks++;
        if (res !== 32'h00FF_0000 || lat != 2 || !rok) begin
            errors++;
            $display("FAIL reset_mid_next: data=%h lat=%0d ready_ok=%0b, want 00ff0000 2 1", res, lat, rok);
        end
        drain(dok);
    endtask

    task automatic test_sweep;
        logic [31:0] d, res, want;
        int          lat;
        bit          bok, rok, dok;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            for (int m = 0; m < 4; m++) begin
                for (int sh = 0; sh < 32; sh++) begin
                    d = (sh % 4 == 0) ? ($urandom | 32'h8000_0000) : $urandom;
                    want = ref_shift(d, sh, 2'(m));
                    do_op(d, 5'(sh), 2'(m), res, lat, bok, rok);
                    checks++;
                    if (res !== want || lat != exp_lat(sh, steps[s]) || !bok || !rok) begin
                        errors++;
                        $display("FAIL sweep step=%0d mode=%0d sh=%0d in=%h: data=%h lat=%0d busy_ok=%0b ready_ok=%0b, want data=%h lat=%0d",
                                 steps[s], m, sh, d, res, lat, bok, rok, want, exp_lat(sh, steps[s]));
                    end
                    drain(dok);
                    checks++;
                    if (!dok) begin
                        errors++;
                        $display("FAIL sweep_drain step=%0d mode=%0d sh=%0d: ready=%b valid=%b busy=%b, want 1 0 0",
                                 steps[s], m, sh, in_ready_m, out_valid_m, busy_m);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_backpressure;
        test_reset_mid;
        test_sweep;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
